// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bridge
// Description : Splits the processor data port between a zero-latency
//               synchronous RAM (low half of the address space) and NCH
//               valid/ready peripheral channels (high half). MMIO accesses
//               stall the processor until the channel answers, times out,
//               or is found to be out of range.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_bridge #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int NCH     = 4,
  parameter int PADDR_W = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_wren,
  input  logic                  cpu_rden,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  output logic                  ram_wren,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [NCH-1:0]        per_valid,
  output logic                  per_we,
  output logic [PADDR_W-1:0]    per_addr,
  output logic [DATA_W-1:0]     per_wdata,
  input  logic [NCH-1:0]        per_ready,
  input  logic [NCH*DATA_W-1:0] per_rdata,
  output logic [7:0]            err_count
);

  localparam int                CH_W         = ADDR_W - 1 - PADDR_W;
  localparam logic [CH_W:0]     C_NCH        = (CH_W+1)'(NCH);
  localparam logic [7:0]        C_WAIT_LAST  = 8'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] C_ERR_RESULT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic                r_we;
  logic [CH_W-1:0]     r_ch;
  logic [PADDR_W-1:0]  r_paddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_result;
  logic [7:0]          r_wait;
  logic [7:0]          r_err;

  logic                w_access;
  logic [CH_W-1:0]     w_req_ch;
  logic                w_legal;
  logic                w_sel_ready;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic                w_timeout;
  logic                w_take;
  logic                w_load;
  logic [DATA_W-1:0]   w_result_val;
  logic                w_err_inc;

  // Address decode: top address bit picks MMIO, the bits below it the channel
  assign w_access  = cpu_addr[ADDR_W-1] & (cpu_wren | cpu_rden);
  assign w_req_ch  = cpu_addr[ADDR_W-2:PADDR_W];
  assign w_legal   = ({1'b0, w_req_ch} < C_NCH);
  assign w_timeout = (r_wait == C_WAIT_LAST);

  // RAM side is a pure pass-through; stores to MMIO space never reach RAM
  assign ram_addr  = cpu_addr;
  assign ram_wdata = cpu_wdata;
  assign ram_wren  = cpu_wren & ~cpu_addr[ADDR_W-1];

  // Load data comes from RAM except in the single completion cycle
  assign cpu_rdata = (r_state == DONE) ? r_result : ram_rdata;

  assign per_we    = r_we;
  assign per_addr  = r_paddr;
  assign per_wdata = r_wdata;
  assign err_count = r_err;

  // One-hot request, raised only while waiting on the latched channel
  for (genvar gi = 0; gi < NCH; gi++) begin : g_valid
    assign per_valid[gi] = (r_state == REQ) && (r_ch == CH_W'(gi));
  end

  // Pick ready/data of the latched channel; every other channel is ignored
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_ch == CH_W'(i)) begin
        w_sel_ready = per_ready[i];
        w_sel_rdata = per_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic, stall generation and completion result selection
  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    w_load       = 1'b0;
    w_result_val = r_result;
    w_err_inc    = 1'b0;
    cpu_stall    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          cpu_stall = 1'b1;
          w_take    = 1'b1;
          if (w_legal) begin
            w_next_state = REQ;
          end else begin
            w_next_state = DONE;
            w_load       = 1'b1;
            w_result_val = C_ERR_RESULT;
            w_err_inc    = 1'b1;
          end
        end
      end
      REQ: begin
        cpu_stall = 1'b1;
        // A ready on the final wait cycle still counts as success
        if (w_sel_ready) begin
          w_next_state = DONE;
          w_load       = 1'b1;
          w_result_val = r_we ? '0 : w_sel_rdata;
        end else if (w_timeout) begin
          w_next_state = DONE;
          w_load       = 1'b1;
          w_result_val = C_ERR_RESULT;
          w_err_inc    = 1'b1;
        end
      end
      DONE: begin
        // Request is still asserted here; it must not start a new access
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Request latches, wait counter, result and saturating error counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_we     <= 1'b0;
      r_ch     <= '0;
      r_paddr  <= '0;
      r_wdata  <= '0;
      r_result <= '0;
      r_wait   <= '0;
      r_err    <= '0;
    end else begin
      if (w_take) begin
        r_we    <= cpu_wren;
        r_ch    <= w_req_ch;
        r_paddr <= cpu_addr[PADDR_W-1:0];
        r_wdata <= cpu_wdata;
        r_wait  <= '0;
      end else if ((r_state == REQ) && !w_sel_ready) begin
        r_wait <= r_wait + 8'd1;
      end
      if (w_load) begin
        r_result <= w_result_val;
      end
      if (w_err_inc && (r_err != 8'hFF)) begin
        r_err <= r_err + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_bridge
// Description : Self-checking bench for mmio_bridge: RAM pass-through table,
//               directed MMIO corner cases and randomized transactions
//               checked against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_bridge;

  localparam int TIMEOUT = 16;

  logic         clock;
  logic         reset;
  logic         cpu_wren;
  logic         cpu_rden;
  logic [11:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         ram_wren;
  logic [11:0]  ram_addr;
  logic [31:0]  ram_wdata;
  logic [31:0]  ram_rdata;
  logic [3:0]   per_valid;
  logic         per_we;
  logic [7:0]   per_addr;
  logic [31:0]  per_wdata;
  logic [3:0]   per_ready;
  logic [127:0] per_rdata;
  logic [7:0]   err_count;

  int checks = 0;
  int errors = 0;
  int model_err = 0;

  mmio_bridge #(
    .ADDR_W(12), .DATA_W(32), .NCH(4), .PADDR_W(8), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_wren(cpu_wren), .cpu_rden(cpu_rden), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .per_valid(per_valid), .per_we(per_we), .per_addr(per_addr),
    .per_wdata(per_wdata), .per_ready(per_ready), .per_rdata(per_rdata),
    .err_count(err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One MMIO access. lat = number of not-ready REQ cycles before ready.
  task automatic mmio_txn(input logic wr, input logic rd, input logic [11:0] addr,
                          input logic [31:0] wd, input int lat, input logic [31:0] rdv);
    int          ch, exp_req, nreq, nstall;
    bit          legal, ok, done;
    logic [31:0] exp_data;
    logic [3:0]  onehot;
    ch       = int'(addr[10:8]);
    legal    = (ch < 4);
    ok       = legal && (lat < TIMEOUT);
    exp_req  = !legal ? 0 : ((lat < TIMEOUT) ? lat + 1 : TIMEOUT);
    exp_data = ok ? (wr ? 32'h0 : rdv) : 32'hFFFF_FFFF;
    if (!ok && model_err < 255) model_err++;
    onehot   = legal ? 4'(1 << ch) : 4'b0;
    for (int i = 0; i < 4; i++) per_rdata[i*32 +: 32] = $urandom;
    if (legal) per_rdata[ch*32 +: 32] = rdv;
    ram_rdata = $urandom;
    if (ram_rdata == exp_data) ram_rdata = ~exp_data;
    cpu_wren  = wr;
    cpu_rden  = rd;
    cpu_addr  = addr;
    cpu_wdata = wd;
    per_ready = 4'b0;
    nreq = 0; nstall = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clock);
      if (!cpu_stall) begin
        done = 1;
      end else begin
        nstall++;
        if (c == 0) chk("mmio_ram_wren", 32'(ram_wren), 32'h0);
        if (per_valid != 4'b0) begin
          nreq++;
          chk("per_valid", 32'(per_valid), 32'(onehot));
          chk("per_we", 32'(per_we), 32'(wr));
          chk("per_addr", 32'(per_addr), 32'(addr[7:0]));
          chk("per_wdata", per_wdata, wd);
          if (nreq == lat + 1) per_ready[ch] = 1'b1;
        end
        @(posedge clock); #1;
        per_ready = 4'($urandom) & ~onehot;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL txn_bound: stall still high after 100 cycles, required DONE");
    end
    chk("done_stall", 32'(cpu_stall), 32'h0);
    chk("done_rdata", cpu_rdata, exp_data);
    chk("done_valid", 32'(per_valid), 32'h0);
    chk("err_count", 32'(err_count), 32'(model_err));
    chk("req_cycles", 32'(nreq), 32'(exp_req));
    chk("stall_cycles", 32'(nstall), 32'(exp_req + 1));
    cpu_wren = 1'b0; cpu_rden = 1'b0; per_ready = 4'b0;
    @(posedge clock); #1;
    chk("idle_after_done", 32'(cpu_stall), 32'h0);
  endtask

  typedef struct {
    logic        wren;
    logic        rden;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rram;
    logic        exp_ram_wren;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [11:0] a;
    logic [1:0]  k;
    cpu_wren = 0; cpu_rden = 0; cpu_addr = 0; cpu_wdata = 0;
    ram_rdata = 0; per_ready = 0; per_rdata = '0; reset = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 12'h010, 32'hA5A5_A5A5, 32'h1111_2222, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 12'h7FF, 32'h0BAD_F00D, 32'hCAFE_BABE, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 12'h000, 32'h1234_0000, 32'h0000_5678, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 12'h900, 32'hDEAD_BEEF, 32'h5555_AAAA, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 12'hFFF, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 12'h7FC, 32'h8000_0001, 32'h7777_8888, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clock);
    ram_rdata = 32'h3C3C_3C3C;
    @(negedge clock);
    chk("rst_err", 32'(err_count), 32'h0);
    chk("rst_valid", 32'(per_valid), 32'h0);
    chk("rst_we", 32'(per_we), 32'h0);
    chk("rst_paddr", 32'(per_addr), 32'h0);
    chk("rst_pwdata", per_wdata, 32'h0);
    chk("rst_stall", 32'(cpu_stall), 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h3C3C_3C3C);
    @(posedge clock); #1;
    reset = 1'b1;

    // RAM pass-through table
    for (int i = 0; i < 6; i++) begin
      cpu_wren = vecs[i].wren; cpu_rden = vecs[i].rden;
      cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata; ram_rdata = vecs[i].rram;
      @(negedge clock);
      chk("ram_wren", 32'(ram_wren), 32'(vecs[i].exp_ram_wren));
      chk("ram_addr", 32'(ram_addr), 32'(vecs[i].addr));
      chk("ram_wdata", ram_wdata, vecs[i].wdata);
      chk("ram_stall", 32'(cpu_stall), 32'(vecs[i].exp_stall));
      chk("ram_rdata", cpu_rdata, vecs[i].rram);
      chk("ram_valid", 32'(per_valid), 32'h0);
      @(posedge clock); #1;
    end
    cpu_wren = 0; cpu_rden = 0;

    // Directed corner cases
    mmio_txn(1'b0, 1'b1, 12'h904, 32'h0, 3, 32'h1234_5678);       // read ch1
    mmio_txn(1'b1, 1'b0, 12'hB10, 32'h5A5A_0001, 100, 32'h0);     // timeout ch3
    mmio_txn(1'b1, 1'b1, 12'h800, 32'h0000_00EE, 0, 32'h9999_9999); // both -> write
    mmio_txn(1'b0, 1'b1, 12'hA33, 32'h0, TIMEOUT - 1, 32'h00C0_FFEE); // ready on last cycle
    mmio_txn(1'b0, 1'b1, 12'h9F0, 32'h0, TIMEOUT, 32'h1357_9BDF);   // one cycle too late
    for (int i = 0; i < 300; i++) mmio_txn(1'b0, 1'b1, 12'hC00, 32'h0, 0, 32'h0);
    chk("err_saturated", 32'(err_count), 32'd255);

    // Reset during the second REQ cycle abandons the access
    cpu_rden = 1'b1; cpu_addr = 12'hA20; per_ready = 4'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_req_valid_hold", 32'(per_valid), 32'h4);
    @(posedge clock); #1;
    reset = 1'b1; cpu_rden = 1'b0; per_ready = 4'b0100;
    @(negedge clock);
    chk("rst_req_valid", 32'(per_valid), 32'h0);
    chk("rst_req_err", 32'(err_count), 32'h0);
    chk("rst_req_stall", 32'(cpu_stall), 32'h0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("late_ready_valid", 32'(per_valid), 32'h0);
    chk("late_ready_err", 32'(err_count), 32'h0);
    per_ready = 4'b0;
    model_err = 0;
    @(posedge clock); #1;

    // Randomized mix of RAM and MMIO accesses
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        cpu_wren = 1'($urandom); cpu_rden = 1'($urandom);
        a = 12'($urandom); a[11] = 1'b0; cpu_addr = a;
        cpu_wdata = $urandom; ram_rdata = $urandom;
        @(negedge clock);
        chk("rnd_ram_wren", 32'(ram_wren), 32'(cpu_wren));
        chk("rnd_ram_stall", 32'(cpu_stall), 32'h0);
        chk("rnd_ram_rdata", cpu_rdata, ram_rdata);
        @(posedge clock); #1;
        cpu_wren = 0; cpu_rden = 0;
      end else begin
        k = 2'($urandom_range(1, 3));
        a = {1'b1, 3'($urandom_range(0, 5)), 8'($urandom)};
        mmio_txn(k[0], k[1], a, $urandom, $urandom_range(0, 18), $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 Parameters SHALL be declared as follows:
- ADDR_W, 12: width of the processor data address.
- DATA_W, 32: width of a data word.
- NCH, 4: number of peripheral channels (1..7).
- PADDR_W, 8: width of the per-channel register address.
- TIMEOUT, 16: maximum cycles to wait for per_ready (2..255).

REQ-002 Ports SHALL be as follows:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- cpu_wren  in  1  processor store strobe.
- cpu_rden  in  1  processor load strobe.
- cpu_addr  in  ADDR_W  processor data address.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data returned to the processor.
- cpu_stall  out  1  processor holds its request while this is high.
- ram_wren  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data (synchronous RAM).
- per_valid  out  NCH  one-hot request, one bit per channel.
- per_we  out  1  request is a write.
- per_addr  out  PADDR_W  register address within the selected channel.
- per_wdata  out  DATA_W  peripheral write data.
- per_ready  in  NCH  per-channel completion.
- per_rdata  in  NCH*DATA_W  read data; channel i occupies bits [i*DATA_W +: DATA_W].
- err_count  out  8  saturating count of failed MMIO accesses.

Function
REQ-003 The address decode SHALL be: cpu_addr[ADDR_W-1]=0 selects RAM; =1 selects MMIO, with channel = cpu_addr[ADDR_W-2:PADDR_W] and per_addr = cpu_addr[PADDR_W-1:0].
REQ-004 The RAM path SHALL be combinational with zero added latency: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_wren=cpu_wren AND RAM-selected.
- ram_wren SHALL be 0 for every MMIO address.
REQ-005 The FSM SHALL have three states, IDLE, REQ and DONE, and SHALL reset to IDLE.
REQ-006 In IDLE, an MMIO access (cpu_wren or cpu_rden) SHALL raise cpu_stall combinationally in the same cycle.
- The bridge SHALL latch we, channel, per_addr and wdata.
- If channel < NCH, next state SHALL be REQ.
- Otherwise the access is illegal: the bridge SHALL load result 0xFFFFFFFF, increment err_count, and go to DONE.
REQ-007 If cpu_wren and cpu_rden are both high, the access SHALL be treated as a write.
REQ-008 In REQ, the latched channel's per_valid bit SHALL be held high with per_we/per_addr/per_wdata stable, and cpu_stall SHALL be 1.
- Other per_valid bits SHALL stay 0.
REQ-009 In REQ, when per_ready[ch]=1 the bridge SHALL capture that channel's per_rdata (0 for writes) and go to DONE.
- per_valid SHALL drop on the following cycle.
REQ-010 In REQ, a wait counter SHALL increment each cycle that per_ready[ch]=0.
- After TIMEOUT such cycles, the bridge SHALL go to DONE with result 0xFFFFFFFF and increment err_count.
- per_ready arriving on the timeout cycle SHALL win; it is not an error.
REQ-011 DONE SHALL last exactly one cycle, with cpu_stall=0 and cpu_rdata=result, then return to IDLE.
- The still-present request SHALL NOT restart a transaction in that cycle.
REQ-012 Outside DONE, cpu_rdata SHALL equal ram_rdata.
REQ-013 err_count SHALL saturate at 255.
REQ-014 per_ready on unselected channels, or in any state other than REQ, SHALL be ignored.

Reset
REQ-015 While reset=0 at a rising edge, the next state SHALL be:
- FSM IDLE, wait counter 0, err_count 0, latched result 0.
- per_valid 0, per_we 0, per_addr 0, per_wdata 0.
REQ-016 Reset asserted in REQ SHALL abandon the transaction with no err_count change, and per_valid SHALL be 0 from the next cycle.
REQ-017 Reset SHALL have no asynchronous effect; the RAM path stays combinational throughout.

Verification
REQ-018 RAM store: cpu_wren=1, addr=0x010, wdata=0xA5A5A5A5 -> ram_wren=1 and cpu_stall=0 in the same cycle; per_valid=0.
REQ-019 MMIO read: cpu_rden=1, addr=0x904, per_ready[1] after 3 cycles with rdata 0x12345678 -> per_valid=4'b0010, per_addr=0x04, stall for 5 cycles, then DONE with cpu_rdata=0x12345678.
REQ-020 Timeout: cpu_wren=1, addr=0xB10, per_ready held 0 -> per_valid[3] high for 16 cycles, then DONE with rdata 0xFFFFFFFF and err_count=1.
REQ-021 Illegal channel: cpu_rden=1, addr=0xC00 -> no per_valid, DONE on the next cycle with 0xFFFFFFFF; err_count saturates at 255 after 300 repeats.
REQ-022 Reset mid-REQ: reset=0 on the 2nd REQ cycle -> IDLE, per_valid=0, err_count=0 after one edge; a late per_ready is ignored.
REQ-023 Simultaneous rden+wren to 0x800 with per_ready[0]=1 on the first REQ cycle -> per_we=1, DONE cpu_rdata=0.
